arith_factor_engine: RTL and testbench



---
 rtl/arith_factor_engine_pkg.sv | 21 ++
 rtl/arith_factor_engine_divider.sv | 54 +++++
 rtl/arith_factor_engine.sv | 142 ++++++++++++++
 tb/tb_arith_factor_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_factor_engine_pkg.sv
// Shared definitions for the factor engine: mode codes, FSM states and default width.
package arith_factor_engine_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_TOTIENT = 2'd0,
    MODE_LPF     = 2'd1,
    MODE_OMEGA   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_DIV    = 3'd2,
    ST_UPD    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/arith_factor_engine_divider.sv
// Restoring sequential divider: one quotient bit per cycle, WIDTH cycles after a go pulse.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;
  logic             fits;

  always_comb begin
    remShift = {rem, quot[WIDTH-1]};
    remDiff  = remShift - {1'b0, dvsr};
    fits     = (remShift >= {1'b0, dvsr});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
    end else if (go) begin
      quot <= dividend;
      rem  <= '0;
      dvsr <= divisor;
      cnt  <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      // Partial remainder is always below the divisor, so the low WIDTH bits suffice.
      rem  <= fits ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
      quot <= {quot[WIDTH-2:0], fits};
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign ready     = (cnt == '0);
  assign quotient  = quot;
  assign remainder = rem;

endmodule

// File: rtl/arith_factor_engine.sv
// Trial-division number-theory engine: totient, largest prime factor, or distinct-prime count.
module arith_factor_engine
  import arith_factor_engine_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             doubleClk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] inputLine,
  output logic [WIDTH-1:0] outputLine,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             err
);

  state_t           state;
  state_t           nextState;
  mode_t            modeQ;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lastp;
  logic [WIDTH-1:0] finAcc;
  logic [2*WIDTH-1:0] dSq;
  logic             errCase;
  logic             finishNow;
  logic             divGo;
  logic             divReady;
  logic [WIDTH-1:0] divQuot;
  logic [WIDTH-1:0] divRem;

  // Fold a freshly found prime factor p into the running result.
  function automatic logic [WIDTH-1:0] updAcc(input mode_t md, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] lp);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   f;
    f    = (p == lp) ? p : p - WIDTH'(1);
    prod = (2*WIDTH)'(a) * (2*WIDTH)'(f);
    case (md)
      MODE_TOTIENT: updAcc = prod[WIDTH-1:0];
      MODE_LPF:     updAcc = p;
      MODE_OMEGA:   updAcc = (p != lp) ? a + WIDTH'(1) : a;
      default:      updAcc = a;
    endcase
  endfunction

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (doubleClk),
    .rst       (rst),
    .go        (divGo),
    .dividend  (m),
    .divisor   (d),
    .ready     (divReady),
    .quotient  (divQuot),
    .remainder (divRem)
  );

  always_comb begin
    dSq       = (2*WIDTH)'(d) * (2*WIDTH)'(d);
    errCase   = (modeQ == MODE_RSVD) || (m == '0);
    finishNow = errCase || (dSq > (2*WIDTH)'(m));
    finAcc    = acc;
    if (errCase)
      finAcc = '0;
    else if (m > WIDTH'(1))
      finAcc = updAcc(modeQ, acc, m, lastp);
  end

  always_ff @(posedge doubleClk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (start) nextState = ST_CHECK;
      ST_CHECK:  nextState = finishNow ? ST_FINISH : ST_DIV;
      ST_DIV:    if (divReady) nextState = ST_UPD;
      ST_UPD:    nextState = ST_CHECK;
      ST_FINISH: nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    divGo = (state == ST_CHECK) && !finishNow;
  end

  always_ff @(posedge doubleClk or posedge rst) begin
    if (rst) begin
      m          <= '0;
      d          <= '0;
      acc        <= '0;
      lastp      <= '0;
      modeQ      <= MODE_TOTIENT;
      outputLine <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          m          <= inputLine;
          d          <= WIDTH'(2);
          lastp      <= '0;
          acc        <= (mode_t'(mode) == MODE_OMEGA) ? '0 : WIDTH'(1);
          modeQ      <= mode_t'(mode);
          outputLine <= '0;
          valid      <= 1'b0;
          err        <= 1'b0;
          busy       <= 1'b1;
        end
        ST_UPD: begin
          // d stays put after a hit so repeated factors are divided out in turn.
          if (divRem == '0) begin
            m     <= divQuot;
            acc   <= updAcc(modeQ, acc, d, lastp);
            lastp <= d;
          end else begin
            d <= (d == WIDTH'(2)) ? WIDTH'(3) : d + WIDTH'(2);
          end
        end
        ST_FINISH: begin
          outputLine <= finAcc;
          err        <= errCase;
          done       <= 1'b1;
          valid      <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_factor_engine.sv
// Directed bench for arith_factor_engine at WIDTH=16 plus an exhaustive WIDTH=8 sweep.
module tb_arith_factor_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic [1:0]  mode16, mode8;
  logic [15:0] in16, out16;
  logic [7:0]  in8, out8;
  logic        busy16, done16, valid16, err16;
  logic        busy8, done8, valid8, err8;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  arith_factor_engine #(.WIDTH(16)) dut16 (
    .doubleClk(clk), .rst(rst), .start(start16), .mode(mode16), .inputLine(in16),
    .outputLine(out16), .busy(busy16), .done(done16), .valid(valid16), .err(err16));

  arith_factor_engine #(.WIDTH(8)) dut8 (
    .doubleClk(clk), .rst(rst), .start(start8), .mode(mode8), .inputLine(in8),
    .outputLine(out8), .busy(busy8), .done(done8), .valid(valid8), .err(err8));

  function automatic int gcd(int a, int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic bit isPrime(int p);
    if (p < 2) return 1'b0;
    for (int q = 2; q * q <= p; q++) if (p % q == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int refPhi(int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (gcd(k, n) == 1) c++;
    return c;
  endfunction

  function automatic int refLpf(int n);
    if (n == 1) return 1;
    for (int p = n; p >= 2; p--) if (n % p == 0 && isPrime(p)) return p;
    return 0;
  endfunction

  function automatic int refOmega(int n);
    int c = 0;
    for (int p = 2; p <= n; p++) if (n % p == 0 && isPrime(p)) c++;
    return c;
  endfunction

  task automatic launch16(input logic [15:0] n, input logic [1:0] md);
    @(negedge clk);
    in16 = n; mode16 = md; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic waitDone16(output int cyc);
    cyc = 0;
    while (done16 !== 1'b1 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    total++;
    if (done16 !== 1'b1) $display("FAIL done16_timeout: done=%b after %0d cycles, required 1", done16, cyc);
    else passed++;
  endtask

  task automatic launch8(input logic [7:0] n, input logic [1:0] md);
    @(negedge clk);
    in8 = n; mode8 = md; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic waitDone8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    total++;
    if (done8 !== 1'b1) $display("FAIL done8_timeout: done=%b after %0d cycles, required 1", done8, cyc);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start16 = 1'b0; start8 = 1'b0;
    mode16 = 2'd0; mode8 = 2'd0; in16 = '0; in8 = '0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({out16, busy16, done16, valid16, err16} !== 20'd0)
      $display("FAIL reset16: out=%0d busy=%b done=%b valid=%b err=%b, required all 0",
               out16, busy16, done16, valid16, err16);
    else passed++;
    total++;
    if ({out8, busy8, done8, valid8, err8} !== 12'd0)
      $display("FAIL reset8: out=%0d busy=%b done=%b valid=%b err=%b, required all 0",
               out8, busy8, done8, valid8, err8);
    else passed++;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy16, done16);
    else passed++;
  endtask

  task automatic test_totient();
    logic [15:0] ns [7]   = '{16'd5040, 16'd30030, 16'd360, 16'd154, 16'd210, 16'd561, 16'd2310};
    logic [15:0] exps [7] = '{16'd1152, 16'd5760, 16'd96, 16'd60, 16'd48, 16'd320, 16'd480};
    int cyc;
    for (int i = 0; i < 7; i++) begin
      launch16(ns[i], 2'd0);
      total++;
      if (busy16 !== 1'b1 || valid16 !== 1'b0)
        $display("FAIL totient_busy n=%0d: busy=%b valid=%b, required 1 0", ns[i], busy16, valid16);
      else passed++;
      waitDone16(cyc);
      total++;
      if (out16 !== exps[i] || err16 !== 1'b0 || busy16 !== 1'b0)
        $display("FAIL totient n=%0d: got %0d err=%b busy=%b, required %0d err=0 busy=0",
                 ns[i], out16, err16, busy16, exps[i]);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (done16 !== 1'b0 || valid16 !== 1'b1 || out16 !== exps[i])
        $display("FAIL totient_hold n=%0d: done=%b valid=%b out=%0d, required 0 1 %0d",
                 ns[i], done16, valid16, out16, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_modes();
    logic [15:0] ns [5]   = '{16'd561, 16'd4, 16'd30030, 16'd1, 16'd1};
    logic [1:0]  mds [5]  = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [15:0] exps [5] = '{16'd17, 16'd2, 16'd6, 16'd0, 16'd1};
    int          lat [5]  = '{-1, 21, -1, 2, 2};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      launch16(ns[i], mds[i]);
      waitDone16(cyc);
      total++;
      if (out16 !== exps[i] || err16 !== 1'b0)
        $display("FAIL mode%0d n=%0d: got %0d err=%b, required %0d err=0", mds[i], ns[i], out16, err16, exps[i]);
      else passed++;
      if (lat[i] >= 0) begin
        total++;
        if (cyc != lat[i])
          $display("FAIL latency n=%0d: done after %0d edges, required %0d", ns[i], cyc, lat[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_errors();
    logic [15:0] ns [3]  = '{16'd0, 16'd100, 16'd0};
    logic [1:0]  mds [3] = '{2'd0, 2'd3, 2'd2};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch16(ns[i], mds[i]);
      waitDone16(cyc);
      total++;
      if (out16 !== 16'd0 || err16 !== 1'b1 || cyc != 2)
        $display("FAIL error_case n=%0d mode=%0d: got %0d err=%b latency=%0d, required 0 err=1 latency=2",
                 ns[i], mds[i], out16, err16, cyc);
      else passed++;
    end
    launch16(16'd7, 2'd0);
    waitDone16(cyc);
    total++;
    if (out16 !== 16'd6 || err16 !== 1'b0)
      $display("FAIL err_clears: got %0d err=%b, required 6 err=0", out16, err16);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int cyc;
    launch16(16'd210, 2'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); in16 = 16'd30030; mode16 = 2'd1; start16 = 1'b1;
      @(negedge clk); start16 = 1'b0;
    end
    #1;
    total++;
    if (busy16 !== 1'b1)
      $display("FAIL busy_hold: busy=%b, required 1", busy16);
    else passed++;
    waitDone16(cyc);
    total++;
    if (out16 !== 16'd48 || err16 !== 1'b0)
      $display("FAIL busy_ignore: got %0d err=%b, required 48 err=0", out16, err16);
    else passed++;
    repeat (30) @(posedge clk); #1;
    total++;
    if (busy16 !== 1'b0 || valid16 !== 1'b1 || out16 !== 16'd48)
      $display("FAIL no_restart: busy=%b valid=%b out=%0d, required 0 1 48", busy16, valid16, out16);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch16(16'd154, 2'd0);
    waitDone16(cyc);
    in16 = 16'd2310; mode16 = 2'd0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    total++;
    if (busy16 !== 1'b1 || valid16 !== 1'b0 || out16 !== 16'd0 || done16 !== 1'b0)
      $display("FAIL b2b_accept: busy=%b valid=%b out=%0d done=%b, required 1 0 0 0",
               busy16, valid16, out16, done16);
    else passed++;
    waitDone16(cyc);
    total++;
    if (out16 !== 16'd480)
      $display("FAIL b2b_result: got %0d, required 480", out16);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    launch16(16'd30030, 2'd0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({out16, busy16, done16, valid16, err16} !== 20'd0)
      $display("FAIL reset_mid: out=%0d busy=%b done=%b valid=%b err=%b, required all 0",
               out16, busy16, done16, valid16, err16);
    else passed++;
    @(negedge clk); rst = 1'b0;
    launch16(16'd210, 2'd0);
    waitDone16(cyc);
    total++;
    if (out16 !== 16'd48 || err16 !== 1'b0)
      $display("FAIL after_reset: got %0d err=%b, required 48 err=0", out16, err16);
    else passed++;
  endtask

  task automatic test_width8();
    int cyc;
    int expv;
    launch8(8'd251, 2'd0);
    waitDone8(cyc);
    total++;
    if (out8 !== 8'd250 || err8 !== 1'b0)
      $display("FAIL prime8: got %0d err=%b, required 250 err=0", out8, err8);
    else passed++;
    for (int n = 1; n < 256; n++) begin
      for (int md = 0; md < 3; md++) begin
        launch8(8'(n), 2'(md));
        waitDone8(cyc);
        case (md)
          0:       expv = refPhi(n);
          1:       expv = refLpf(n);
          default: expv = refOmega(n);
        endcase
        total++;
        if (out8 !== 8'(expv) || err8 !== 1'b0)
          $display("FAIL sweep8 n=%0d mode=%0d: got %0d err=%b, required %0d err=0", n, md, out8, err8, expv);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_totient();
    test_modes();
    test_errors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
